reg_file_2w_sb: RTL and testbench

Parametrised register file for the CPU datapath. It has two asynchronous read ports and two synchronous write ports, with write-to-read bypass and an optional hardwired zero register. It also keeps a per-register busy scoreboard, so the issue stage can detect read-after-write hazards on in-flight results. It replaces the fixed 8x16, single-write-port register file wherever a second writeback path is needed.

---
 rtl/reg_file_2w_sb.sv | 98 +++++++++
 tb/tb_reg_file_2w_sb.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_2w_sb.sv
// reg_file_2w_sb
//   Register file with two combinational read ports, two synchronous write
//   ports, write-to-read bypass, an optional hardwired zero register, and a
//   per-register busy scoreboard for RAW hazard detection at issue.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   write_en/addr/data_{1,2}        write ports (port 2 wins on same address)
//   reserve_en, reserve_addr        mark a register busy (result in flight)
//   read_addr_{1,2}                 read addresses
//   read_data_{1,2}                 combinational read data (with bypass)
//   busy_{1,2}                      registered busy bit of each read address
//   busy_vec                        full scoreboard, bit i = register i busy
module reg_file_2w_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     write_en_1,
  input  logic [ADDR_W-1:0]        write_addr_1,
  input  logic [DATA_W-1:0]        write_data_1,
  input  logic                     write_en_2,
  input  logic [ADDR_W-1:0]        write_addr_2,
  input  logic [DATA_W-1:0]        write_data_2,
  input  logic                     reserve_en,
  input  logic [ADDR_W-1:0]        reserve_addr,
  input  logic [ADDR_W-1:0]        read_addr_1,
  input  logic [ADDR_W-1:0]        read_addr_2,
  output logic [DATA_W-1:0]        read_data_1,
  output logic [DATA_W-1:0]        read_data_2,
  output logic                     busy_1,
  output logic                     busy_2,
  output logic [(1<<ADDR_W)-1:0]   busy_vec
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]             busy_q, busy_d;

  // Port 2 is applied last so it overrides port 1 on an address collision.
  always_comb begin
    regs_d = regs_q;
    if (write_en_1) regs_d[write_addr_1] = write_data_1;
    if (write_en_2) regs_d[write_addr_2] = write_data_2;
    if (ZERO_REG != 0) regs_d[0] = '0;
  end

  // Clear on writeback first, then set on reserve: a new producer issued in
  // the same cycle as an older result returns keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (write_en_1) busy_d[write_addr_1] = 1'b0;
    if (write_en_2) busy_d[write_addr_2] = 1'b0;
    if (reserve_en) busy_d[reserve_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read ports, one instance of the read mux per port.
  logic [1:0][ADDR_W-1:0] rd_addr;
  logic [1:0][DATA_W-1:0] rd_data;

  assign rd_addr[0] = read_addr_1;
  assign rd_addr[1] = read_addr_2;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic hit_1, hit_2, is_zero;
    // Bypass is gated by rst_n so a write presented during reset never leaks.
    assign hit_1   = (BYPASS != 0) && rst_n && write_en_1 && (write_addr_1 == rd_addr[p]);
    assign hit_2   = (BYPASS != 0) && rst_n && write_en_2 && (write_addr_2 == rd_addr[p]);
    assign is_zero = (ZERO_REG != 0) && (rd_addr[p] == '0);
    assign rd_data[p] = (!rst_n || is_zero) ? '0 :
                        hit_2               ? write_data_2 :
                        hit_1               ? write_data_1 :
                                              regs_q[rd_addr[p]];
  end

  assign read_data_1 = rd_data[0];
  assign read_data_2 = rd_data[1];

  // Busy is deliberately not bypassed; it reflects registered state only.
  assign busy_vec = busy_q;
  assign busy_1   = busy_q[read_addr_1];
  assign busy_2   = busy_q[read_addr_2];

endmodule

// File: tb/tb_reg_file_2w_sb.sv
// Testbench for reg_file_2w_sb. Three instances share stimulus:
//   d=0 default (ZERO_REG=0, BYPASS=1), d=1 BYPASS=0, d=2 ZERO_REG=1.
// Expected values are pushed to a queue as stimulus is driven and popped
// and compared once the combinational outputs have settled.
module tb_reg_file_2w_sb;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       we1, we2, res_en;
  logic [2:0] wa1, wa2, res_a, ra1, ra2;
  logic [15:0] wd1, wd2;

  logic [15:0] rd1 [3];
  logic [15:0] rd2 [3];
  logic        b1  [3];
  logic        b2  [3];
  logic [7:0]  bv  [3];

  always #5 clk = ~clk;

  reg_file_2w_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) u_d0 (
    .clk(clk), .rst_n(rst_n),
    .write_en_1(we1), .write_addr_1(wa1), .write_data_1(wd1),
    .write_en_2(we2), .write_addr_2(wa2), .write_data_2(wd2),
    .reserve_en(res_en), .reserve_addr(res_a),
    .read_addr_1(ra1), .read_addr_2(ra2),
    .read_data_1(rd1[0]), .read_data_2(rd2[0]),
    .busy_1(b1[0]), .busy_2(b2[0]), .busy_vec(bv[0]));

  reg_file_2w_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) u_d1 (
    .clk(clk), .rst_n(rst_n),
    .write_en_1(we1), .write_addr_1(wa1), .write_data_1(wd1),
    .write_en_2(we2), .write_addr_2(wa2), .write_data_2(wd2),
    .reserve_en(res_en), .reserve_addr(res_a),
    .read_addr_1(ra1), .read_addr_2(ra2),
    .read_data_1(rd1[1]), .read_data_2(rd2[1]),
    .busy_1(b1[1]), .busy_2(b2[1]), .busy_vec(bv[1]));

  reg_file_2w_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) u_d2 (
    .clk(clk), .rst_n(rst_n),
    .write_en_1(we1), .write_addr_1(wa1), .write_data_1(wd1),
    .write_en_2(we2), .write_addr_2(wa2), .write_data_2(wd2),
    .reserve_en(res_en), .reserve_addr(res_a),
    .read_addr_1(ra1), .read_addr_2(ra2),
    .read_data_1(rd1[2]), .read_data_2(rd2[2]),
    .busy_1(b1[2]), .busy_2(b2[2]), .busy_vec(bv[2]));

  // sig: 0 read_data_1, 1 read_data_2, 2 busy_1, 3 busy_2, 4 busy_vec
  typedef struct {
    string       tag;
    int          dut;
    int          sig;
    logic [15:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [15:0] obs(input int d, input int s);
    case (s)
      0:       return rd1[d];
      1:       return rd2[d];
      2:       return {15'd0, b1[d]};
      3:       return {15'd0, b2[d]};
      default: return {8'd0, bv[d]};
    endcase
  endfunction

  task automatic expect_v(input string tag, input int d, input int s, input logic [15:0] e);
    exp_t x;
    x.tag = tag; x.dut = d; x.sig = s; x.exp = e;
    q.push_back(x);
  endtask

  task automatic check_all();
    exp_t x;
    logic [15:0] o;
    #1;
    while (q.size() > 0) begin
      x = q.pop_front();
      o = obs(x.dut, x.sig);
      n_chk++;
      assert (o === x.exp) else begin
        n_fail++;
        $error("FAIL %s dut%0d sig%0d observed=%h expected=%h", x.tag, x.dut, x.sig, o, x.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we1 = 0; we2 = 0; res_en = 0;
  endtask

  initial begin
    rst_n = 0; idle();
    wa1 = 0; wa2 = 0; wd1 = 0; wd2 = 0; res_a = 0; ra1 = 0; ra2 = 0;

    // Reset state
    #2;
    for (int d = 0; d < 3; d++) begin
      expect_v("rst_rd1", d, 0, 16'h0);
      expect_v("rst_bv",  d, 4, 16'h0);
    end
    check_all();
    tick(); tick();
    rst_n = 1;

    // 1. load reg i = 7 - i, read back crosswise
    for (int i = 0; i < 8; i++) begin
      we1 = 1; wa1 = 3'(i); wd1 = 16'(7 - i);
      tick();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      ra1 = 3'(i); ra2 = 3'(7 - i);
      for (int d = 0; d < 3; d++) begin
        expect_v("load_rd1", d, 0, (d == 2 && i == 0) ? 16'h0 : 16'(7 - i));
        expect_v("load_rd2", d, 1, (d == 2 && i == 7) ? 16'h0 : 16'(i));
      end
      check_all();
    end

    // 2. both ports write reg3: port 2 wins, bypass forwards port 2
    we1 = 1; wa1 = 3; wd1 = 16'hAAAA;
    we2 = 1; wa2 = 3; wd2 = 16'h5555;
    ra1 = 3;
    expect_v("dual_byp",   0, 0, 16'h5555);
    expect_v("dual_nobyp", 1, 0, 16'h0004);
    expect_v("dual_byp_z", 2, 0, 16'h5555);
    check_all();
    tick(); idle();
    for (int d = 0; d < 3; d++) expect_v("dual_stored", d, 0, 16'h5555);
    check_all();

    // 3. same-cycle bypass on read port 2
    ra2 = 5; we1 = 1; wa1 = 5; wd1 = 16'h1234;
    expect_v("byp_rd2",   0, 1, 16'h1234);
    expect_v("nobyp_rd2", 1, 1, 16'h0002);
    check_all();
    tick(); idle();
    expect_v("nobyp_after", 1, 1, 16'h1234);
    expect_v("byp_after",   0, 1, 16'h1234);
    check_all();

    // 4. scoreboard: reserve, not visible until the edge
    res_en = 1; res_a = 2; ra1 = 2;
    expect_v("rsv_pre_bv", 0, 4, 16'h0000);
    check_all();
    tick(); idle();
    expect_v("rsv_bv", 0, 4, 16'h0004);
    expect_v("rsv_b1", 0, 2, 16'h0001);
    expect_v("rsv_bv_z", 2, 4, 16'h0004);
    check_all();
    // writeback: data bypassed, busy not bypassed
    we2 = 1; wa2 = 2; wd2 = 16'h2222;
    expect_v("wb_rd1_byp", 0, 0, 16'h2222);
    expect_v("wb_b1_hold", 0, 2, 16'h0001);
    check_all();
    tick(); idle();
    expect_v("wb_bv_clr", 0, 4, 16'h0000);
    expect_v("wb_b1_clr", 0, 2, 16'h0000);
    check_all();
    // reserve + write same address: stays busy
    res_en = 1; res_a = 2; we2 = 1; wa2 = 2; wd2 = 16'h3333;
    tick(); idle();
    expect_v("rsvwr_b1", 0, 2, 16'h0001);
    expect_v("rsvwr_rd", 0, 0, 16'h3333);
    check_all();
    // reserve of already-busy register
    res_en = 1; res_a = 2;
    tick(); idle();
    expect_v("rsv_again_bv", 0, 4, 16'h0004);
    check_all();

    // 5. zero register: writes and reserves to addr 0 dropped
    we1 = 1; wa1 = 0; wd1 = 16'hFFFF; res_en = 1; res_a = 0; ra1 = 0;
    expect_v("zr_rd1_byp", 2, 0, 16'h0000);
    expect_v("nz_rd1_byp", 0, 0, 16'hFFFF);
    check_all();
    tick(); idle();
    expect_v("zr_rd1",   2, 0, 16'h0000);
    expect_v("zr_bv",    2, 4, 16'h0004);
    expect_v("zr_b1",    2, 2, 16'h0000);
    expect_v("nz_rd1",   0, 0, 16'hFFFF);
    expect_v("nz_bv",    0, 4, 16'h0005);
    check_all();

    // 6. async reset mid-cycle
    res_en = 1; res_a = 1; tick();
    res_a = 4; tick(); idle();
    expect_v("pre_rst_bv",   0, 4, 16'h0017);
    expect_v("pre_rst_bv_z", 2, 4, 16'h0016);
    ra1 = 6; ra2 = 1;
    expect_v("pre_rst_rd1",  0, 0, 16'h0001);
    check_all();
    #2;
    rst_n = 0;
    we1 = 1; wa1 = 6; wd1 = 16'hBEEF; res_en = 1; res_a = 6;
    for (int d = 0; d < 3; d++) begin
      expect_v("rst_mid_rd1", d, 0, 16'h0);
      expect_v("rst_mid_rd2", d, 1, 16'h0);
      expect_v("rst_mid_bv",  d, 4, 16'h0);
      expect_v("rst_mid_b2",  d, 3, 16'h0);
    end
    check_all();
    tick();
    expect_v("rst_edge_rd1", 0, 0, 16'h0);
    expect_v("rst_edge_bv",  0, 4, 16'h0);
    check_all();
    idle(); rst_n = 1;
    tick();
    for (int d = 0; d < 3; d++) begin
      expect_v("post_rst_rd1", d, 0, 16'h0);
      expect_v("post_rst_rd2", d, 1, 16'h0);
      expect_v("post_rst_bv",  d, 4, 16'h0);
    end
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
